// File: rtl/fp25519_pkg.sv
// Shared constants for the 25519 field datapath: modulus, add/sub opcodes and
// the command sequencer state encoding.
package fp25519_pkg;

  localparam logic [255:0] P_25519 =
    256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/fp_regfile.sv
// Field-element register file: one write port shared by host load and
// writeback, two combinational operand read ports, one registered host read port.
module fp_regfile
  import fp25519_pkg::*;
#(
  parameter int BIT_LENGTH = 256,
  parameter int NREG       = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_we,
  input  logic [AW-1:0]         ld_addr,
  input  logic [BIT_LENGTH-1:0] ld_data,
  input  logic                  wb_we,
  input  logic [AW-1:0]         wb_addr,
  input  logic [BIT_LENGTH-1:0] wb_data,
  input  logic [AW-1:0]         ra_addr,
  input  logic [AW-1:0]         rb_addr,
  output logic [BIT_LENGTH-1:0] ra_data,
  output logic [BIT_LENGTH-1:0] rb_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [BIT_LENGTH-1:0] rd_data
);

  logic [BIT_LENGTH-1:0] mem_q [NREG];
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [BIT_LENGTH-1:0] wdata;

  // Host loads only happen in IDLE and writeback only in WB, so the two
  // strobes never collide; writeback is given priority regardless.
  always_comb begin
    we    = ld_we | wb_we;
    waddr = wb_we ? wb_addr : ld_addr;
    wdata = wb_we ? wb_data : ld_data;
  end

  // Storage is deliberately not reset so contents survive a mid-operation reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem_q[rd_addr];
  end

  assign ra_data = mem_q[ra_addr];
  assign rb_data = mem_q[rb_addr];

endmodule

// File: rtl/fp_addsub_seq.sv
// Command sequencer feeding the external mod-p add_sub unit: fetches operands
// from the register file, waits one cycle for add_sub, then writes the result back.
module fp_addsub_seq
  import fp25519_pkg::*;
#(
  parameter int BIT_LENGTH = 256,
  parameter int NREG       = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [AW-1:0]         cmd_a,
  input  logic [AW-1:0]         cmd_b,
  input  logic [AW-1:0]         cmd_d,
  output logic                  busy,
  output logic                  done,
  input  logic                  ld_en,
  input  logic [AW-1:0]         ld_addr,
  input  logic [BIT_LENGTH-1:0] ld_data,
  output logic                  ld_err,
  input  logic [AW-1:0]         rd_addr,
  output logic [BIT_LENGTH-1:0] rd_data,
  output logic                  as_mode,
  output logic [BIT_LENGTH-1:0] as_a,
  output logic [BIT_LENGTH-1:0] as_b,
  input  logic [BIT_LENGTH-1:0] as_c
);

  localparam logic [BIT_LENGTH-1:0] P_MOD = BIT_LENGTH'(P_25519);

  seq_state_e            state_q;
  logic                  op_q;
  logic [AW-1:0]         a_q, b_q, d_q;
  logic                  done_q, ld_err_q, as_mode_q;
  logic [BIT_LENGTH-1:0] as_a_q, as_b_q;
  logic [BIT_LENGTH-1:0] ra_data, rb_data;
  logic                  ld_in_range, ld_we, wb_we;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE outside reset.
  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign ld_err    = ld_err_q;
  assign as_mode   = as_mode_q;
  assign as_a      = as_a_q;
  assign as_b      = as_b_q;

  assign ld_in_range = (ld_data < P_MOD);
  assign ld_we       = ld_en && (state_q == ST_IDLE) && ld_in_range && !rst;
  assign wb_we       = (state_q == ST_WB) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      d_q       <= '0;
      done_q    <= 1'b0;
      ld_err_q  <= 1'b0;
      as_mode_q <= OP_ADD;
      as_a_q    <= '0;
      as_b_q    <= '0;
    end else begin
      done_q   <= 1'b0;
      ld_err_q <= ld_en && ((state_q != ST_IDLE) || !ld_in_range);
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            a_q     <= cmd_a;
            b_q     <= cmd_b;
            d_q     <= cmd_d;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          as_a_q    <= ra_data;
          as_b_q    <= rb_data;
          as_mode_q <= op_q;
          state_q   <= ST_EXEC;
        end
        ST_EXEC: state_q <= ST_WB;
        ST_WB: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fp_regfile #(
    .BIT_LENGTH(BIT_LENGTH),
    .NREG      (NREG),
    .AW        (AW)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .ld_we  (ld_we),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .wb_we  (wb_we),
    .wb_addr(d_q),
    .wb_data(as_c),
    .ra_addr(a_q),
    .rb_addr(b_q),
    .ra_data(ra_data),
    .rb_data(rb_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

endmodule
